// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch and field-split front end driving the program ROM read port
// Optional jump redirect (jump_valid/jump_addr) is built when FETCH_JUMP_EN is defined.
module fetch_unit #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rom_read,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        instr_opcode,
  output logic [5:0]        instr_dst,
  output logic [5:0]        instr_src,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              halted
`ifdef FETCH_JUMP_EN
  ,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ipc;
  logic              capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      ipc   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (capture) begin
        ir  <= rom_data;
        ipc <= pc;
      end
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    capture = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          pc_n    = '0;
          state_n = REQ;
        end
      end
      REQ: state_n = WAIT;
      WAIT: begin
        capture = 1'b1;
        // The all-zero word is HALT: it is latched but never presented as valid.
        if (rom_data == '0) begin
          state_n = HALTED;
        end else begin
          state_n = HOLD;
          pc_n    = pc + 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
`ifdef FETCH_JUMP_EN
    // A redirect overrides transfer and HALT detection and drops any in-flight word.
    if (jump_valid) begin
      state_n = REQ;
      pc_n    = jump_addr;
      capture = 1'b0;
    end
`endif
  end

  assign rom_read     = (state == REQ);
  assign rom_addr     = rom_read ? pc : '0;
  assign instr_valid  = (state == HOLD);
  assign instr_opcode = ir[15:12];
  assign instr_dst    = ir[11:6];
  assign instr_src    = ir[5:0];
  assign instr_pc     = ipc;
  assign busy         = (state == REQ) || (state == WAIT) || (state == HOLD);
  assign halted       = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a registered ROM model
module tb_fetch_unit;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              instr_ready = 1'b0;
  logic              rom_read;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              instr_valid;
  logic [3:0]        instr_opcode;
  logic [5:0]        instr_dst;
  logic [5:0]        instr_src;
  logic [ADDR_W-1:0] instr_pc;
  logic              busy;
  logic              halted;
`ifdef FETCH_JUMP_EN
  logic              jump_valid = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_read(rom_read), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_dst(instr_dst), .instr_src(instr_src),
    .instr_pc(instr_pc), .busy(busy), .halted(halted)
`ifdef FETCH_JUMP_EN
    , .jump_valid(jump_valid), .jump_addr(jump_addr)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:7];
  int reads  = 0;
  int edge_n = 0;
  int base   = 0;

  always @(posedge clk) begin
    if (rom_read) begin
      rom_data <= rom[rom_addr];
      reads = reads + 1;
    end
  end
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [2:0]  pc;
    logic [15:0] word;
    int          cyc;
  } exp_t;
  exp_t sb [$];
  exp_t e;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_xfer: got pc %0d expected no transfer", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("xfer_pc", 32'(instr_pc), 32'(e.pc));
        chk("xfer_opcode", 32'(instr_opcode), 32'(e.word[15:12]));
        chk("xfer_dst", 32'(instr_dst), 32'(e.word[11:6]));
        chk("xfer_src", 32'(instr_src), 32'(e.word[5:0]));
        if (e.cyc >= 0) chk("xfer_cycle", 32'(edge_n - base + 1), 32'(e.cyc));
      end
    end
  end

  task automatic push(input int pc, input int cyc);
    exp_t x;
    x.pc   = 3'(pc);
    x.word = rom[pc];
    x.cyc  = cyc;
    sb.push_back(x);
  endtask

  task automatic load_rom(input int zero_at);
    for (int i = 0; i < 8; i++) rom[i] = 16'h1041 + 16'(i) * 16'h1111;
    if (zero_at >= 0) rom[zero_at] = 16'h0000;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rom_read"}, 32'(rom_read), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_outputs_zero("rst");
    chk("rst_fields", 32'({instr_opcode, instr_dst, instr_src, instr_pc}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reads = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = edge_n;
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget && !halted; i++) begin
      @(posedge clk); #1;
    end
    chk("halted_reached", 32'(halted), 1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !instr_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("valid_reached", 32'(instr_valid), 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = '0;

    // Seven instructions then HALT, ready tied high: one per 3 cycles.
    load_rom(7);
    reset_dut();
    instr_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(i, 3 + 3 * i);
    do_start();
    chk("first_rom_read", 32'(rom_read), 1);
    chk("first_rom_addr", 32'(rom_addr), 0);
    wait_halted(40);
    chk("t1_busy_after_halt", 32'(busy), 0);
    chk("t1_valid_after_halt", 32'(instr_valid), 0);
    chk("t1_rom_reads", 32'(reads), 8);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // Backpressure: held word must stay put with no further ROM reads.
    load_rom(2);
    rom[0] = 16'h4042;
    reset_dut();
    instr_ready = 1'b0;
    push(0, -1);
    do_start();
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(instr_valid), 1);
      chk("t2_hold_opcode", 32'(instr_opcode), 32'h4);
      chk("t2_hold_dst", 32'(instr_dst), 1);
      chk("t2_hold_src", 32'(instr_src), 2);
      chk("t2_hold_no_read", 32'(rom_read), 0);
      @(posedge clk); #1;
    end
    push(1, -1);
    instr_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_next_read", 32'(rom_read), 1);
    chk("t2_next_addr", 32'(rom_addr), 1);
    wait_halted(20);
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // Restart from HALTED, with a stray start pulse while busy.
    load_rom(3);
    for (int i = 0; i < 3; i++) push(i, -1);
    do_start();
    chk("t5_read", 32'(rom_read), 1);
    chk("t5_addr", 32'(rom_addr), 0);
    chk("t5_halted_clear", 32'(halted), 0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_halted(30);
    chk("t5_sb_empty", 32'(sb.size()), 0);

    // All words nonzero: PC wraps from 7 back to 0.
    load_rom(-1);
    reset_dut();
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(i % 8, -1);
    do_start();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("t3_sb_drained", 32'(sb.size()), 0);
    chk("t3_not_halted", 32'(halted), 0);

    // Asynchronous reset in WAIT drops the in-flight word immediately.
    load_rom(2);
    reset_dut();
    instr_ready = 1'b1;
    do_start();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("t4_async");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_idle_read", 32'(rom_read), 0);
    push(0, -1);
    push(1, -1);
    do_start();
    chk("t4_restart_addr", 32'(rom_addr), 0);
    wait_halted(20);
    chk("t4_sb_empty", 32'(sb.size()), 0);

`ifdef FETCH_JUMP_EN
    // Jump during HOLD of address 2 redirects to address 5.
    load_rom(6);
    reset_dut();
    instr_ready = 1'b1;
    push(0, -1);
    push(1, -1);
    do_start();
    for (int i = 0; i < 30 && !(rom_read && rom_addr == 3'd2); i++) begin
      @(posedge clk); #1;
    end
    instr_ready = 1'b0;
    wait_valid(10);
    chk("t6_held_pc", 32'(instr_pc), 2);
    jump_valid = 1'b1;
    jump_addr  = 3'd5;
    @(posedge clk); #1;
    jump_valid = 1'b0;
    chk("t6_valid_dropped", 32'(instr_valid), 0);
    chk("t6_jump_read", 32'(rom_read), 1);
    chk("t6_jump_addr", 32'(rom_addr), 5);
    push(5, -1);
    instr_ready = 1'b1;
    wait_halted(20);
    chk("t6_sb_empty", 32'(sb.size()), 0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
